// File: rtl/cnn1d_pkg.sv
// Shared helpers and types for the 1-D CNN blocks: integer log2, accumulator
// sizing and the transposed-convolution FSM state encoding.
package cnn1d_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Full-precision product plus enough headroom to sum n of them.
   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + clog2(n);
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_EMIT  = 2'd3
   } conv_state_e;

endpackage

// File: rtl/ola_buffer.sv
// Overlap-add accumulator array: per-slot add, indexed read of the output
// slice, and a shift by SHIFT slots once the oldest slots have been emitted.
module ola_buffer
   import cnn1d_pkg::*;
#(
   parameter int DEPTH   = 5,
   parameter int ACC_W   = 27,
   parameter int SHIFT   = 2,
   parameter int IDX_W   = 3,
   parameter int OUT_MSB = 11,
   parameter int OUT_W   = 12
) (
   input  logic                    clk,
   input  logic                    clear_i,
   input  logic                    add_en_i,
   input  logic [IDX_W-1:0]        add_idx_i,
   input  logic signed [ACC_W-1:0] addend_i,
   input  logic [IDX_W-1:0]        rd_idx_i,
   output logic [OUT_W-1:0]        rd_slice_o,
   input  logic                    shift_i
);

   logic signed [ACC_W-1:0] acc_q [DEPTH];
   logic signed [ACC_W-1:0] acc_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) acc_d[i] = acc_q[i];
      if (shift_i) begin
         for (int i = 0; i < DEPTH; i++) acc_d[i] = '0;
         for (int i = SHIFT; i < DEPTH; i++) acc_d[i-SHIFT] = acc_q[i];
      end else if (add_en_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (add_idx_i == IDX_W'(i)) acc_d[i] = acc_q[i] + addend_i;
         end
      end
   end

   always_comb begin
      rd_slice_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_idx_i == IDX_W'(i)) rd_slice_o = acc_q[i][OUT_MSB -: OUT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) acc_q[i] <= acc_d[i];
      end
   end

endmodule

// File: rtl/conv1d_transpose.sv
// Upsampling 1-D transposed convolution (overlap-add) on a signed AXI-stream.
// Optional ReLU on the output is enabled with `define CONV1D_TRANSPOSE_RELU_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for an input beat (ready_in high)
//  ST_MAC   | one tap per cycle: x*w[k] into the product register
//  ST_DRAIN | final product added into its accumulator slot
//  ST_EMIT  | STRIDE finished slots loaded into the output register
module conv1d_transpose
   import cnn1d_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int FILTER_SIZE = 5,
   parameter int STRIDE      = 2,
   parameter int FRACTION    = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  conv1dt_ready_in,
   input  logic                                  conv1dt_valid_in,
   input  logic [DATA_WIDTH-1:0]                 conv1dt_data_in,
   input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] conv1dt_weights,
   input  logic [DATA_WIDTH-1:0]                 conv1dt_bias,
   input  logic                                  conv1dt_ready_out,
   output logic                                  conv1dt_valid_out,
   output logic [DATA_WIDTH-1:0]                 conv1dt_data_out
);

   localparam int ACC_W   = acc_width(DATA_WIDTH, FILTER_SIZE);
   localparam int PROD_W  = 2 * DATA_WIDTH;
   localparam int OUT_MSB = PROD_W - 1 - (DATA_WIDTH - FRACTION);
   localparam int TAP_W   = (FILTER_SIZE > 1) ? clog2(FILTER_SIZE) : 1;
   localparam int EMIT_W  = (STRIDE > 1) ? clog2(STRIDE) : 1;
   localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(FILTER_SIZE - 1);
   localparam logic [EMIT_W-1:0] LAST_EMIT = EMIT_W'(STRIDE - 1);

   conv_state_e state_q, state_d;

   logic [DATA_WIDTH-1:0]    x_q, x_d;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     prod_vld_q, prod_vld_d;
   logic [TAP_W-1:0]         prod_idx_q, prod_idx_d;
   logic [EMIT_W-1:0]        emit_q, emit_d;
   logic                     valid_q, valid_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;

   logic                     ready_in;
   logic                     accept;
   logic                     issue;
   logic                     load;
   logic                     shift;
   logic [DATA_WIDTH-1:0]    w_sel;
   logic signed [PROD_W-1:0] mult;
   logic [DATA_WIDTH-1:0]    slot;
   logic [DATA_WIDTH-1:0]    biased;
   logic [DATA_WIDTH-1:0]    out_val;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_MAC;
         ST_MAC:   if (tap_q == LAST_TAP) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_EMIT;
         ST_EMIT:  if (shift) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready_in = (state_q == ST_IDLE) && !rst;
      accept   = ready_in && conv1dt_valid_in;
      issue    = (state_q == ST_MAC);
      load     = (state_q == ST_EMIT) && (!valid_q || conv1dt_ready_out);
      shift    = load && (emit_q == LAST_EMIT);
   end

   always_comb begin
      w_sel = '0;
      for (int k = 0; k < FILTER_SIZE; k++) begin
         if (tap_q == TAP_W'(k)) w_sel = conv1dt_weights[k];
      end
   end

   assign mult = PROD_W'($signed(x_q)) * PROD_W'($signed(w_sel));

   ola_buffer #(
      .DEPTH   (FILTER_SIZE),
      .ACC_W   (ACC_W),
      .SHIFT   (STRIDE),
      .IDX_W   (TAP_W),
      .OUT_MSB (OUT_MSB),
      .OUT_W   (DATA_WIDTH)
   ) u_ola (
      .clk        (clk),
      .clear_i    (rst),
      .add_en_i   (prod_vld_q),
      .add_idx_i  (prod_idx_q),
      .addend_i   (ACC_W'(prod_q)),
      .rd_idx_i   (TAP_W'(emit_q)),
      .rd_slice_o (slot),
      .shift_i    (shift)
   );

   // Bias add wraps at DATA_WIDTH; no saturation.
   assign biased = slot + conv1dt_bias;

`ifdef CONV1D_TRANSPOSE_RELU_EN
   assign out_val = biased[DATA_WIDTH-1] ? '0 : biased;
`else
   assign out_val = biased;
`endif

   always_comb begin
      x_d        = x_q;
      tap_d      = tap_q;
      prod_d     = prod_q;
      prod_vld_d = issue;
      prod_idx_d = prod_idx_q;
      emit_d     = emit_q;
      valid_d    = valid_q;
      data_d     = data_q;
      if (accept) begin
         x_d   = conv1dt_data_in;
         tap_d = '0;
      end
      if (issue) begin
         prod_d     = mult;
         prod_idx_d = tap_q;
         tap_d      = (tap_q == LAST_TAP) ? '0 : tap_q + TAP_W'(1);
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = out_val;
         emit_d  = (emit_q == LAST_EMIT) ? '0 : emit_q + EMIT_W'(1);
      end else if (conv1dt_ready_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         tap_q      <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         prod_idx_q <= '0;
         emit_q     <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         x_q        <= x_d;
         tap_q      <= tap_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         prod_idx_q <= prod_idx_d;
         emit_q     <= emit_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
      end
   end

   assign conv1dt_ready_in  = ready_in;
   assign conv1dt_valid_out = valid_q;
   assign conv1dt_data_out  = data_q;

endmodule

// File: tb/tb_conv1d_transpose.sv
// Scoreboard bench for conv1d_transpose: instance A (FRACTION=0) and instance B
// (FRACTION=4), both FILTER_SIZE=3, STRIDE=2, checked against an overlap-add model.
module tb_conv1d_transpose;

   logic clk = 1'b0;
   logic rst;

   logic             vld_in  [2];
   logic [11:0]      din     [2];
   logic [2:0][11:0] wts     [2];
   logic [11:0]      bias    [2];
   logic             rdy_out [2];

   logic        a_rdy_in, b_rdy_in;
   logic        a_vld_out, b_vld_out;
   logic [11:0] a_dout, b_dout;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_out_a  = 0;
   int     q_a[$];
   int     q_b[$];
   longint macc[2][3];

   always #5 clk = ~clk;

   conv1d_transpose #(.DATA_WIDTH(12), .FILTER_SIZE(3), .STRIDE(2), .FRACTION(0)) dut_a (
      .clk(clk), .rst(rst),
      .conv1dt_ready_in(a_rdy_in), .conv1dt_valid_in(vld_in[0]), .conv1dt_data_in(din[0]),
      .conv1dt_weights(wts[0]), .conv1dt_bias(bias[0]),
      .conv1dt_ready_out(rdy_out[0]), .conv1dt_valid_out(a_vld_out), .conv1dt_data_out(a_dout)
   );

   conv1d_transpose #(.DATA_WIDTH(12), .FILTER_SIZE(3), .STRIDE(2), .FRACTION(4)) dut_b (
      .clk(clk), .rst(rst),
      .conv1dt_ready_in(b_rdy_in), .conv1dt_valid_in(vld_in[1]), .conv1dt_data_in(din[1]),
      .conv1dt_weights(wts[1]), .conv1dt_bias(bias[1]),
      .conv1dt_ready_out(rdy_out[1]), .conv1dt_valid_out(b_vld_out), .conv1dt_data_out(b_dout)
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy_in_of(input int s);
      return (s != 0) ? b_rdy_in : a_rdy_in;
   endfunction

   function automatic logic vld_out_of(input int s);
      return (s != 0) ? b_vld_out : a_vld_out;
   endfunction

   function automatic int qsize(input int s);
      return (s != 0) ? q_b.size() : q_a.size();
   endfunction

   function automatic int model_out(input longint acc, input int frac, input logic signed [11:0] b);
      logic signed [11:0] sl;
      logic signed [11:0] r;
      sl = 12'(acc >>> frac);
      r  = sl + b;
`ifdef CONV1D_TRANSPOSE_RELU_EN
      if (r < 0) r = '0;
`endif
      return int'(r);
   endfunction

   function automatic void model_push(input int s, input logic signed [11:0] x);
      int frac;
      int v;
      frac = (s != 0) ? 4 : 0;
      for (int k = 0; k < 3; k++) macc[s][k] += longint'(x) * longint'($signed(wts[s][k]));
      for (int j = 0; j < 2; j++) begin
         v = model_out(macc[s][j], frac, $signed(bias[s]));
         if (s != 0) q_b.push_back(v);
         else        q_a.push_back(v);
      end
      macc[s][0] = macc[s][2];
      macc[s][1] = 0;
      macc[s][2] = 0;
   endfunction

   always @(negedge clk) begin
      if (!rst && a_vld_out && rdy_out[0]) begin
         if (q_a.size() == 0) check_eq("a_spurious_out", q_a.size(), 1);
         else check_eq("a_out", longint'($signed(a_dout)), longint'(q_a.pop_front()));
         n_out_a++;
      end
   end

   always @(negedge clk) begin
      if (!rst && b_vld_out && rdy_out[1]) begin
         if (q_b.size() == 0) check_eq("b_spurious_out", q_b.size(), 1);
         else check_eq("b_out", longint'($signed(b_dout)), longint'(q_b.pop_front()));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      q_a.delete();
      q_b.delete();
      for (int s = 0; s < 2; s++) for (int k = 0; k < 3; k++) macc[s][k] = 0;
      @(posedge clk);
      #1;
      check_eq("rst_ready_in_low", a_rdy_in, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_a_valid_out", a_vld_out, 0);
      check_eq("rst_a_data_out", a_dout, 0);
      check_eq("rst_a_ready_in", a_rdy_in, 1);
      check_eq("rst_b_valid_out", b_vld_out, 0);
      check_eq("rst_b_ready_in", b_rdy_in, 1);
   endtask

   task automatic send(input int s, input logic signed [11:0] x);
      int n;
      n = 0;
      @(negedge clk);
      vld_in[s] = 1'b1;
      din[s]    = x;
      while (!rdy_in_of(s) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_in_of(s)) begin
         check_eq("send_ready_timeout", rdy_in_of(s), 1);
         vld_in[s] = 1'b0;
         return;
      end
      @(posedge clk);
      model_push(s, x);
      #1 vld_in[s] = 1'b0;
   endtask

   task automatic drain(input int s);
      int n;
      n = 0;
      while (n < 300 && !(qsize(s) == 0 && rdy_in_of(s) && !vld_out_of(s))) begin
         @(negedge clk);
         n++;
      end
      check_eq((s != 0) ? "b_drain_q_empty" : "a_drain_q_empty", qsize(s), 0);
      check_eq((s != 0) ? "b_drain_idle" : "a_drain_idle", vld_out_of(s), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst       = 1'b1;
      vld_in[0] = 1'b0;  vld_in[1] = 1'b0;
      din[0]    = '0;    din[1]    = '0;
      wts[0]    = {12'd3, 12'd2, 12'd1};
      wts[1]    = {12'd0, 12'd0, 12'h020};
      bias[0]   = '0;    bias[1]   = '0;
      rdy_out[0] = 1'b1; rdy_out[1] = 1'b1;
      repeat (3) @(posedge clk);
      do_reset();

      // Overlap-add: 1,2 then 5,4; x=0 afterwards exposes the [6,0,0] tail
      send(0, 12'sd1);
      send(0, 12'sd2);
      send(0, 12'sd0);
      drain(0);

      // Latency from accept (edge 0) to valid_out
      send(0, 12'sd1);
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
         if (e <= 5) check_eq("lat_ready_in_busy", a_rdy_in, 0);
         if (e == 4) check_eq("lat_valid_not_early", a_vld_out, 0);
         if (e == 5) check_eq("lat_valid_rise", a_vld_out, 1);
         if (e == 6) check_eq("lat_ready_in_back", a_rdy_in, 1);
      end
      drain(0);

      // Downstream stall holds the first output
      do_reset();
      rdy_out[0] = 1'b0;
      base = n_out_a;
      send(0, 12'sd1);
      n = 0;
      while (!a_vld_out && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("stall_valid_up", a_vld_out, 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("stall_hold_valid", a_vld_out, 1);
         check_eq("stall_hold_data", longint'($signed(a_dout)), longint'(q_a[0]));
      end
      @(posedge clk);
      #1 rdy_out[0] = 1'b1;
      drain(0);
      check_eq("stall_beat_count", n_out_a - base, 2);

      // Negative input, with and without bias
      do_reset();
      send(0, -12'sd1);
      drain(0);
      do_reset();
      bias[0] = 12'sd5;
      send(0, -12'sd1);
      drain(0);
      bias[0] = '0;

      // Reset in the middle of MAC discards partial sums
      do_reset();
      send(0, 12'sd1);
      drain(0);
      send(0, 12'sd2);
      @(posedge clk);
      #1;
      do_reset();
      send(0, 12'sd1);
      drain(0);

      // Fractional scaling on instance B, then a wrapping product
      send(1, 12'h010);
      drain(1);
      wts[1][0] = 12'h7FF;
      send(1, 12'h7FF);
      drain(1);

      // Random samples with random downstream backpressure
      do_reset();
      fork
         begin
            for (int i = 0; i < 10; i++) send(0, 12'($urandom_range(0, 4095)));
         end
         begin
            repeat (120) begin
               @(posedge clk);
               #1 rdy_out[0] = 1'($urandom_range(0, 1));
            end
         end
      join
      @(posedge clk);
      #1 rdy_out[0] = 1'b1;
      drain(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
